// File: rtl/packet_generator.sv
// Framed packet generator: three fixed header bytes, a variable-length payload
// pulled from a valid-only source, then an XOR checksum byte with a done pulse.
module packet_generator #(
  parameter logic [7:0]  HDR0  = 8'hAA,
  parameter logic [7:0]  HDR1  = 8'h55,
  parameter logic [7:0]  HDR2  = 8'hF0,
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] payload_len,
  input  logic [7:0]       pay_data,
  input  logic             pay_valid,
  output logic             pay_ready,
  output logic [7:0]       tx_byte,
  output logic             tx_valid,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHdr  = 2'd1,
    StPay  = 2'd2,
    StCsum = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic             tx_valid_q, tx_valid_d;
  logic             done_q, done_d;
  logic [7:0]       csum_q, csum_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [LEN_W-1:0] count_inc;
  logic [1:0]       hdr_idx_q, hdr_idx_d;
  logic [LEN_W-1:0] len_q, len_d;

  assign count_inc = count_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    tx_byte_d  = 8'h00;
    tx_valid_d = 1'b0;
    done_d     = 1'b0;
    csum_d     = csum_q;
    count_d    = count_q;
    hdr_idx_d  = hdr_idx_q;
    len_d      = len_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          len_d      = payload_len;
          csum_d     = 8'h00;
          count_d    = '0;
          tx_byte_d  = HDR0;
          tx_valid_d = 1'b1;
          hdr_idx_d  = 2'd1;
          state_d    = StHdr;
        end
      end

      StHdr: begin
        tx_valid_d = 1'b1;
        if (hdr_idx_q == 2'd1) begin
          tx_byte_d = HDR1;
          hdr_idx_d = 2'd2;
        end else begin
          tx_byte_d = HDR2;
          hdr_idx_d = 2'd0;
          state_d   = (len_q != '0) ? StPay : StCsum;
        end
      end

      StPay: begin
        // A missing source byte leaves a zeroed, invalid bubble on the stream.
        if (pay_valid) begin
          tx_byte_d  = pay_data;
          tx_valid_d = 1'b1;
          csum_d     = csum_q ^ pay_data;
          count_d    = count_inc;
          if (count_inc == len_q) begin
            state_d = StCsum;
          end
        end
      end

      StCsum: begin
        tx_byte_d  = csum_q;
        tx_valid_d = 1'b1;
        done_d     = 1'b1;
        state_d    = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      tx_byte_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      csum_q     <= 8'h00;
      count_q    <= '0;
      hdr_idx_q  <= 2'd0;
      len_q      <= '0;
    end else begin
      state_q    <= state_d;
      tx_byte_q  <= tx_byte_d;
      tx_valid_q <= tx_valid_d;
      done_q     <= done_d;
      csum_q     <= csum_d;
      count_q    <= count_d;
      hdr_idx_q  <= hdr_idx_d;
      len_q      <= len_d;
    end
  end

  assign pay_ready = (state_q == StPay);
  assign busy      = (state_q != StIdle);
  assign tx_byte   = tx_byte_q;
  assign tx_valid  = tx_valid_q;
  assign done      = done_q;
  assign state     = state_q;

endmodule

// File: tb/tb_packet_generator.sv
// Scoreboard bench for packet_generator: directed packets push expected bytes,
// a monitor pops and compares every tx_valid byte.
module tb_packet_generator;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] payload_len;
  logic [7:0] pay_data;
  logic       pay_valid;
  logic       pay_ready;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       busy;
  logic       done;
  logic [1:0] state;

  packet_generator dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .payload_len(payload_len),
    .pay_data   (pay_data),
    .pay_valid  (pay_valid),
    .pay_ready  (pay_ready),
    .tx_byte    (tx_byte),
    .tx_valid   (tx_valid),
    .busy       (busy),
    .done       (done),
    .state      (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    logic       d;
  } exp_t;

  typedef struct {
    logic [7:0] b;
    int         stall;
  } src_t;

  exp_t exp_q[$];
  src_t src_q[$];

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int bubble_cnt = 0;
  int pr_cnt = 0;
  int valid_cnt = 0;
  bit src_flush = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic pe(input logic [7:0] b, input logic d);
    exp_t e;
    e.b = b;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic ps(input logic [7:0] b, input int stall);
    src_t s;
    s.b = b;
    s.stall = stall;
    src_q.push_back(s);
  endtask

  task automatic pe_hdr();
    pe(8'hAA, 1'b0);
    pe(8'h55, 1'b0);
    pe(8'hF0, 1'b0);
  endtask

  task automatic pulse_start(input logic [3:0] len);
    @(negedge clk);
    payload_len = len;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns at the negedge where done is visible.
  task automatic wait_done(input string name);
    int n = 0;
    @(negedge clk);
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got no done expected done within 200 cycles", name);
    end
  endtask

  // Monitor: every valid byte must match the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        if (pay_ready) pr_cnt++;
        if (tx_valid) begin
          valid_cnt++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_tx: got %0h expected no byte", tx_byte);
          end else begin
            e = exp_q.pop_front();
            check("tx_byte", tx_byte, e.b);
            check("tx_done", done, e.d);
            if (done) done_cnt++;
          end
        end else begin
          if (busy) bubble_cnt++;
          check("invalid_byte", tx_byte, 0);
          check("invalid_done", done, 0);
        end
      end
    end
  end

  // Payload source: presents the head byte, honouring per-byte stall cycles.
  initial begin
    bit   pend = 1'b0;
    src_t h;
    pay_valid = 1'b0;
    pay_data = 8'h00;
    forever begin
      @(negedge clk);
      if (src_flush) begin
        pend = 1'b0;
        src_flush = 1'b0;
      end
      if (pend && src_q.size() > 0) src_q.delete(0);
      pend = 1'b0;
      pay_valid = 1'b0;
      pay_data = 8'h00;
      if (src_q.size() > 0) begin
        h = src_q[0];
        if (pay_ready && h.stall > 0) begin
          h.stall--;
          src_q[0] = h;
        end else begin
          pay_valid = 1'b1;
          pay_data = h.b;
          pend = pay_ready;
        end
      end
    end
  end

  initial begin
    int dsnap;
    reset = 1'b1;
    start = 1'b0;
    payload_len = 4'd0;
    repeat (2) @(negedge clk);
    check("rst_state", state, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_byte", tx_byte, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_pay_ready", pay_ready, 0);
    reset = 1'b0;

    // Basic: 11 ^ 22 = 33
    bubble_cnt = 0;
    valid_cnt = 0;
    ps(8'h11, 0);
    ps(8'h22, 0);
    pe_hdr();
    pe(8'h11, 1'b0);
    pe(8'h22, 1'b0);
    pe(8'h33, 1'b1);
    pulse_start(4'd2);
    wait_done("basic");
    check("basic_drained", exp_q.size(), 0);
    check("basic_no_bubble", bubble_cnt, 0);
    check("basic_valid_cnt", valid_cnt, 6);

    // Zero length: payload phase skipped
    pr_cnt = 0;
    pe_hdr();
    pe(8'h00, 1'b1);
    pulse_start(4'd0);
    wait_done("zero");
    check("zero_pay_ready", pr_cnt, 0);
    check("zero_drained", exp_q.size(), 0);

    // Stall: two bubbles before second byte; 5A ^ 3C ^ 81 = E7
    bubble_cnt = 0;
    ps(8'h5A, 0);
    ps(8'h3C, 2);
    ps(8'h81, 0);
    pe_hdr();
    pe(8'h5A, 1'b0);
    pe(8'h3C, 1'b0);
    pe(8'h81, 1'b0);
    pe(8'hE7, 1'b1);
    pulse_start(4'd3);
    wait_done("stall");
    check("stall_bubbles", bubble_cnt, 2);
    check("stall_drained", exp_q.size(), 0);

    // Back-to-back with start held high
    ps(8'h77, 0);
    ps(8'h0F, 0);
    pe_hdr();
    pe(8'h77, 1'b0);
    pe(8'h77, 1'b1);
    pe_hdr();
    pe(8'h0F, 1'b0);
    pe(8'h0F, 1'b1);
    @(negedge clk);
    payload_len = 4'd1;
    start = 1'b1;
    wait_done("b2b_first");
    @(negedge clk);
    check("b2b_no_gap", tx_valid, 1);
    start = 1'b0;
    wait_done("b2b_second");
    repeat (4) @(negedge clk);
    check("b2b_drained", exp_q.size(), 0);
    check("b2b_idle", state, 0);

    // start / payload_len changes while busy are ignored; A1 ^ B2 = 13
    ps(8'hA1, 0);
    ps(8'hB2, 0);
    pe_hdr();
    pe(8'hA1, 1'b0);
    pe(8'hB2, 1'b0);
    pe(8'h13, 1'b1);
    pulse_start(4'd2);
    @(negedge clk);
    start = 1'b1;
    payload_len = 4'd7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    payload_len = 4'd0;
    wait_done("ignore");
    repeat (6) @(negedge clk);
    check("ignore_drained", exp_q.size(), 0);
    check("ignore_busy", busy, 0);

    // Asynchronous reset during payload
    ps(8'h01, 0);
    ps(8'h02, 0);
    ps(8'h03, 0);
    ps(8'h04, 0);
    pe_hdr();
    pe(8'h01, 1'b0);
    pe(8'h02, 1'b0);
    pulse_start(4'd4);
    repeat (4) @(negedge clk);
    check("mid_state_pay", state, 2);
    dsnap = done_cnt;
    #1 reset = 1'b1;
    #1;
    check("async_state", state, 0);
    check("async_tx_valid", tx_valid, 0);
    check("async_tx_byte", tx_byte, 0);
    check("async_done", done, 0);
    check("async_busy", busy, 0);
    check("async_pre_drain", exp_q.size(), 0);
    src_q.delete();
    src_flush = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_state", state, 0);
    check("post_rst_valid", tx_valid, 0);
    check("post_rst_no_done", done_cnt, dsnap);
    ps(8'h99, 0);
    pe_hdr();
    pe(8'h99, 1'b0);
    pe(8'h99, 1'b1);
    pulse_start(4'd1);
    wait_done("post_rst");
    check("post_rst_drained", exp_q.size(), 0);

    // Maximum length: XOR of 01..0F is 00
    bubble_cnt = 0;
    valid_cnt = 0;
    pe_hdr();
    for (int i = 1; i <= 15; i++) begin
      ps(8'(i), 0);
      pe(8'(i), 1'b0);
    end
    pe(8'h00, 1'b1);
    pulse_start(4'd15);
    wait_done("max");
    check("max_valid_cnt", valid_cnt, 19);
    check("max_no_bubble", bubble_cnt, 0);
    check("max_drained", exp_q.size(), 0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish by 100000");
    $fatal(1, "watchdog expired");
  end

endmodule
